bus_sram_target: RTL and testbench
==================================

Name: bus_sram_target

Overview:
- Responder (target) end of the core's word bus: the bus the core drives with address, start, write, write data and byte enables, and completes on ready with read data.
- Sits behind the core arbiter in simulation and FPGA tops, as on-chip SRAM with programmable wait states.
- Serves one transaction at a time, never reorders, and reports out-of-range accesses through a sticky error flag.

Parameters:
- DEPTH, 4096: memory size in 32-bit words; power of two, at least 2.
- BASE, 0: word address (ptr units) of the first word; must be DEPTH-aligned.
- WAIT_STATES, 1: extra cycles inserted before ready; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_addr  in  30 (ptr)  word address; sampled on accept.
- bus_start  in  1  request strobe; single-cycle pulse per transaction.
- bus_write  in  1  1 = write, 0 = read; sampled on accept.
- bus_data_wr  in  32  write data; sampled on accept.
- bus_data_be  in  4  byte enables; bit i covers bits [8i+7:8i]; sampled on accept.
- bus_ready  out  1  one-cycle completion pulse.
- bus_data_rd  out  32  read data, valid only while bus_ready=1.
- busy  out  1  transaction accepted and not yet completed.
- oob_err  out  1  sticky flag: an access fell outside BASE..BASE+DEPTH-1.

Behaviour:
- Reset, asynchronous on rst_n low:
  - bus_ready=0, bus_data_rd=0, busy=0, oob_err=0; FSM goes to IDLE; wait counter=0.
  - Memory contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: bus_start=1 accepts the request. Latch addr, write, data_wr and be; set busy=1. Go to WAIT if WAIT_STATES>0 (counter loads WAIT_STATES-1), otherwise go to RESP.
  - WAIT: counter decrements each cycle; at 0 go to RESP.
  - RESP: bus_ready=1 for exactly this cycle. Reads drive bus_data_rd. Writes commit in this cycle's clock edge.
  - RESP then goes to IDLE, or accepts a new request directly if bus_start=1 in the RESP cycle (back-to-back).
- Latency: start accepted at edge T; bus_ready is high during cycle T+1+WAIT_STATES. Peak throughput is 1 transaction per 1+WAIT_STATES cycles.
- Read: bus_data_rd = mem[addr-BASE] in the RESP cycle. bus_data_rd returns to 0 when bus_ready=0; the bench checks this.
- Write:
  - Only bytes with be[i]=1 are updated; others keep their value.
  - be=0000 writes nothing but still completes with ready.
  - A write returns bus_data_rd=0.
- Read after write to the same address, back-to-back, returns the new data. The write commits at the RESP edge and the read's RESP comes at least 1 cycle later.
- Out of range (addr<BASE or addr>=BASE+DEPTH):
  - The transaction still completes with normal latency. Read data = 0; the write is dropped.
  - oob_err sets at the RESP edge and stays set until reset.
- bus_start while busy, outside the RESP cycle, is a protocol violation:
  - It is ignored and has no effect on state.
  - A simulation-only assertion flags it.
- Latched fields are immune to bus input changes after accept.
- Reset mid-transaction: the transaction is abandoned and ready is never issued. A pending write does not commit.
- The memory array is inferable as a single-port synchronous RAM: at most one access per cycle, performed in the RESP cycle. Read data may be registered from the last WAIT cycle; visible timing must match the above.

Test Plan:
- WAIT_STATES=1, BASE=0. Write addr 0x10, data 0xDEADBEEF, be=1111, then read 0x10. Expect ready 2 cycles after each start, read data 0xDEADBEEF, busy high between start and ready.
- Partial write: preload 0x11223344 at 0x20, then write data 0xAABBCCDD with be=0101, then read. Expect 0x11BB33DD.
- WAIT_STATES=0, back-to-back: start asserted in each RESP cycle for read, write, read at 0x5. Expect ready every cycle, final read returns the written value, no assertion fires.
- BASE=0x100, DEPTH=256. Read 0x0FF, then write 0x200. Expect both complete with read data 0, memory unchanged, oob_err=1 after the first RESP and staying set.
- Protocol violation: WAIT_STATES=3 with a second start 1 cycle after accept. Expect it ignored, a single ready at T+4, latched address unchanged.
- Reset mid-op: write 0xCAFEF00D to 0x8 (old value 0x0), pull rst_n low during WAIT. Expect ready never pulses, outputs 0 immediately, and a later read of 0x8 returns 0x0.

Source files
------------

// File: rtl/bus_sram_target.sv
// On-chip SRAM responder for the core word bus: one transaction in flight,
// programmable wait states, sticky out-of-range error flag.
module bus_sram_target #(
    parameter int unsigned DEPTH       = 4096,
    parameter logic [29:0] BASE        = 30'd0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] bus_addr,
    input  logic        bus_start,
    input  logic        bus_write,
    input  logic [31:0] bus_data_wr,
    input  logic [3:0]  bus_data_be,
    output logic        bus_ready,
    output logic [31:0] bus_data_rd,
    output logic        busy,
    output logic        oob_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a one-cycle bus_start in IDLE (or in the RESP cycle) is accepted
    // at that clock edge; bus_ready pulses for exactly one cycle WAIT_STATES+1
    // cycles later, and bus_data_rd is meaningful only during that pulse.
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rd_q, rd_d;
    logic        oob_q, oob_d;

    logic        accept;
    logic        wr_en;
    logic [29:0] rd_addr;
    logic        rd_is_read;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [29:0] a);
        return a[29:AW] == BASE[29:AW];
    endfunction

    assign wr_en = (state_q == S_RESP) && write_q && in_range(addr_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        oob_d      = oob_q;
        rd_d       = '0;
        accept     = 1'b0;
        rd_addr    = bus_addr;
        rd_is_read = !bus_write;

        case (state_q)
            S_IDLE: accept = bus_start;
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (!in_range(addr_q)) oob_d = 1'b1;
                accept  = bus_start;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            addr_d  = bus_addr;
            write_d = bus_write;
            wdata_d = bus_data_wr;
            be_d    = bus_data_be;
            if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = S_RESP;
            end
        end

        // Read data is fetched on the edge entering RESP; with zero wait states
        // that edge may also commit the previous write, so forward its bytes.
        if (state_q == S_WAIT) begin
            rd_addr    = addr_q;
            rd_is_read = !write_q;
        end
        if (state_d == S_RESP && rd_is_read && in_range(rd_addr)) begin
            rd_d = mem[rd_addr[AW-1:0]];
            if (wr_en && addr_q == rd_addr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_q[i]) rd_d[8*i +: 8] = wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            oob_q   <= oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[addr_q[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus_ready   = (state_q == S_RESP);
    assign bus_data_rd = rd_q;
    assign busy        = (state_q != S_IDLE);
    assign oob_err     = oob_q;
    assign dbg_state   = state_q;

`ifndef SYNTHESIS
    // A start while waiting is dropped by the FSM; flag it without stopping the run.
    a_no_start_while_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus_start && state_q == S_WAIT))
        else $warning("bus_sram_target: bus_start ignored while a transaction is in flight");
`endif

endmodule

// File: tb/tb_bus_sram_target.sv
// Scoreboard bench for bus_sram_target: four instances cover the wait-state,
// back-to-back, out-of-range and protocol-violation configurations.
module tb_bus_sram_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] bus_addr;
  logic        bus_start;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_data_be;
  int          sel;
  int          cyc = 0;

  logic        start_v [4];
  logic        ready_v [4];
  logic [31:0] rd_v    [4];
  logic        busy_v  [4];
  logic        oob_v   [4];
  logic [1:0]  dbg_v   [4];

  logic        ready_m, busy_m, oob_m;
  logic [31:0] rd_m;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start_v[0] = bus_start && (sel == 0);
  assign start_v[1] = bus_start && (sel == 1);
  assign start_v[2] = bus_start && (sel == 2);
  assign start_v[3] = bus_start && (sel == 3);
  assign ready_m = ready_v[sel];
  assign rd_m    = rd_v[sel];
  assign busy_m  = busy_v[sel];
  assign oob_m   = oob_v[sel];

  bus_sram_target #(.DEPTH(4096), .BASE(30'h0), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(start_v[0]),
    .bus_write(bus_write), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
    .bus_ready(ready_v[0]), .bus_data_rd(rd_v[0]), .busy(busy_v[0]),
    .oob_err(oob_v[0]), .dbg_state(dbg_v[0]));

  bus_sram_target #(.DEPTH(16), .BASE(30'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(start_v[1]),
    .bus_write(bus_write), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
    .bus_ready(ready_v[1]), .bus_data_rd(rd_v[1]), .busy(busy_v[1]),
    .oob_err(oob_v[1]), .dbg_state(dbg_v[1]));

  bus_sram_target #(.DEPTH(256), .BASE(30'h100), .WAIT_STATES(1)) u_oob (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(start_v[2]),
    .bus_write(bus_write), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
    .bus_ready(ready_v[2]), .bus_data_rd(rd_v[2]), .busy(busy_v[2]),
    .oob_err(oob_v[2]), .dbg_state(dbg_v[2]));

  bus_sram_target #(.DEPTH(16), .BASE(30'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(start_v[3]),
    .bus_write(bus_write), .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
    .bus_ready(ready_v[3]), .bus_data_rd(rd_v[3]), .busy(busy_v[3]),
    .oob_err(oob_v[3]), .dbg_state(dbg_v[3]));

  function automatic int ws_of(input int s);
    case (s)
      0: return 1;
      1: return 0;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ready pulse; data must be zero otherwise.
  always @(negedge clk) begin
    if (ready_m) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ready", 32'd1, 32'd0);
      end else begin
        logic [31:0] d;
        int          c;
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check_eq("rd_data", rd_m, d);
        check_eq("ready_cycle", cyc, c);
      end
    end else begin
      check_eq("rd_idle_zero", rd_m, 32'd0);
    end
  end

  // Call right after a negedge; returns at the next negedge with inputs scrambled.
  task automatic send(input logic [29:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_d, input bit push);
    bus_addr    = a;
    bus_write   = w;
    bus_data_wr = d;
    bus_data_be = be;
    bus_start   = 1'b1;
    if (push) begin
      exp_q.push_back(exp_d);
      exp_cyc_q.push_back(cyc + 1 + ws_of(sel));
    end
    @(negedge clk);
    bus_start   = 1'b0;
    check_eq("busy_after_accept", {31'd0, busy_m}, 32'd1);
    bus_addr    = 30'($urandom);
    bus_write   = 1'($urandom_range(0, 1));
    bus_data_wr = $urandom;
    bus_data_be = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 0; bus_start = 1'b0; bus_addr = '0;
    bus_write = 1'b0; bus_data_wr = '0; bus_data_be = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", {31'd0, ready_m}, 32'd0);
    check_eq("reset_rd", rd_m, 32'd0);
    check_eq("reset_busy", {31'd0, busy_m}, 32'd0);
    check_eq("reset_oob", {31'd0, oob_m}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One wait state: full write, read back, partial write, empty byte mask.
    send(30'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1);          wait_done();
    send(30'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1);          wait_done();
    send(30'h20, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b1);          wait_done();
    send(30'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b1);       wait_done();
    send(30'h20, 1'b0, 32'h0, 4'hF, 32'h11BB33DD, 1'b1);          wait_done();
    send(30'h20, 1'b1, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1);       wait_done();
    send(30'h20, 1'b0, 32'h0, 4'hF, 32'h11BB33DD, 1'b1);          wait_done();
    check_eq("oob_clear_in_range", {31'd0, oob_m}, 32'd0);

    // Zero wait states, back-to-back read/write/read with forwarding.
    sel = 1;
    @(negedge clk);
    send(30'h5, 1'b1, 32'h01020304, 4'hF, 32'h0, 1'b1);           wait_done();
    send(30'h5, 1'b0, 32'h0, 4'hF, 32'h01020304, 1'b1);
    send(30'h5, 1'b1, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b1);
    send(30'h5, 1'b0, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b1);
    send(30'h6, 1'b1, 32'h12345678, 4'b1001, 32'h0, 1'b1);
    send(30'h5, 1'b0, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b1);
    wait_done();

    // BASE=0x100, DEPTH=256: boundaries and out-of-range on both sides.
    sel = 2;
    @(negedge clk);
    send(30'h100, 1'b1, 32'h0BADCAFE, 4'hF, 32'h0, 1'b1);         wait_done();
    send(30'h1FF, 1'b1, 32'h600DD00D, 4'hF, 32'h0, 1'b1);         wait_done();
    check_eq("oob_boundaries_ok", {31'd0, oob_m}, 32'd0);
    send(30'h0FF, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);                wait_done();
    check_eq("oob_set_low", {31'd0, oob_m}, 32'd1);
    send(30'h200, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);         wait_done();
    check_eq("oob_sticky", {31'd0, oob_m}, 32'd1);
    send(30'h100, 1'b0, 32'h0, 4'hF, 32'h0BADCAFE, 1'b1);         wait_done();
    send(30'h1FF, 1'b0, 32'h0, 4'hF, 32'h600DD00D, 1'b1);         wait_done();
    check_eq("oob_still_set", {31'd0, oob_m}, 32'd1);

    // Three wait states: a start one cycle after accept must be ignored.
    sel = 3;
    @(negedge clk);
    send(30'h3, 1'b1, 32'h11111111, 4'hF, 32'h0, 1'b1);           wait_done();
    send(30'h7, 1'b1, 32'h22222222, 4'hF, 32'h0, 1'b1);           wait_done();
    send(30'h3, 1'b1, 32'h13572468, 4'hF, 32'h0, 1'b1);
    bus_addr = 30'h7; bus_write = 1'b1; bus_data_wr = 32'hFFFFFFFF;
    bus_data_be = 4'hF; bus_start = 1'b1;
    @(negedge clk);
    bus_start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    send(30'h3, 1'b0, 32'h0, 4'hF, 32'h13572468, 1'b1);           wait_done();
    send(30'h7, 1'b0, 32'h0, 4'hF, 32'h22222222, 1'b1);           wait_done();

    // Reset during the wait state abandons the pending write.
    sel = 0;
    @(negedge clk);
    send(30'h8, 1'b1, 32'h00000000, 4'hF, 32'h0, 1'b1);           wait_done();
    send(30'h8, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ready", {31'd0, ready_m}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, busy_m}, 32'd0);
    check_eq("rst_mid_rd", rd_m, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    sel = 2;
    #1;
    check_eq("rst_clears_oob", {31'd0, oob_m}, 32'd0);
    sel = 0;
    @(negedge clk);
    send(30'h8, 1'b0, 32'h0, 4'hF, 32'h00000000, 1'b1);           wait_done();
    send(30'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1);          wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
